// File: rtl/hd44780_ctrl.sv
// HD44780 character-LCD controller for PCF8574-style I2C backpacks (4-bit mode).
// Turns INIT/WRITE/GOTO/CLEAR/BACKLIGHT commands into expander bytes on a
// valid/ready stream, tracks the cursor, wraps lines and enforces settle times.
// Settle parameters (T_*) are expected to be at least 1.
module hd44780_ctrl #(
  parameter int   ROWS       = 2,
  parameter int   COLS       = 16,
  parameter int   T_PWRUP    = 750000,
  parameter int   T_INIT     = 250000,
  parameter int   T_CMD      = 2500,
  parameter int   T_LONG     = 100000,
  parameter logic BL_DEFAULT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] cmd,
  input  logic [7:0] cmd_data,
  input  logic [1:0] cmd_row,
  input  logic [5:0] cmd_col,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       init_done,
  output logic       err,
  output logic [1:0] cursor_row,
  output logic [5:0] cursor_col
);

  typedef enum logic [2:0] {IDLE, PWRUP, NIB_E1, NIB_E0, WAIT, NEXT} state_t;
  typedef enum logic [2:0] {OP_INIT, OP_WRITE, OP_ADDR, OP_CLEAR, OP_BL} op_t;

  state_t      state_q, state_d;
  op_t         op_q, op_d;
  logic [3:0]  step_q, step_d;
  logic [7:0]  byte_q, byte_d;
  logic        rs_q, rs_d;
  logic        single_q, single_d;
  logic        nowait_q, nowait_d;
  logic [31:0] wlen_q, wlen_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        bl_q, bl_d;
  logic        init_done_q, init_done_d;
  logic        err_q, err_d;
  logic [1:0]  row_q, row_d;
  logic [5:0]  col_q, col_d;

  logic        launch;
  logic [7:0]  l_byte;
  logic        l_rs;
  logic        l_single;
  logic [31:0] l_wlen;
  logic [1:0]  nrow;
  logic [7:0]  ini_byte;
  logic        ini_single;
  logic [31:0] ini_wlen;

  // Set-DDRAM instruction for a row/column position
  function automatic logic [7:0] ddram_cmd(input logic [1:0] r, input logic [5:0] c);
    logic [7:0] a;
    a = {2'b00, c} + (r[0] ? 8'h40 : 8'h00) + (r[1] ? 8'(COLS) : 8'h00);
    return a | 8'h80;
  endfunction

  // Init program table: instruction, single-nibble flag and settle time per step
  always_comb begin
    ini_byte   = 8'h01;
    ini_single = 1'b0;
    ini_wlen   = 32'(T_CMD);
    case (step_q)
      4'd0:       begin ini_byte = 8'h30; ini_single = 1'b1; ini_wlen = 32'(T_INIT); end
      4'd1, 4'd2: begin ini_byte = 8'h30; ini_single = 1'b1; end
      4'd3:       begin ini_byte = 8'h20; ini_single = 1'b1; end
      4'd4:       ini_byte = (ROWS == 1) ? 8'h20 : 8'h28;
      4'd5:       ini_byte = 8'h0C;
      4'd6:       ini_byte = 8'h06;
      default:    ini_wlen = 32'(T_LONG);
    endcase
  end

  // Next-state logic; a launch request loads a new instruction into the nibble emitter
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    step_d      = step_q;
    byte_d      = byte_q;
    rs_d        = rs_q;
    single_d    = single_q;
    nowait_d    = nowait_q;
    wlen_d      = wlen_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    bl_d        = bl_q;
    init_done_d = init_done_q;
    err_d       = 1'b0;
    row_d       = row_q;
    col_d       = col_q;
    launch      = 1'b0;
    l_byte      = '0;
    l_rs        = 1'b0;
    l_single    = 1'b0;
    l_wlen      = 32'(T_CMD);
    nrow        = (32'(row_q) + 32'd1 >= 32'(ROWS)) ? 2'd0 : row_q + 2'd1;

    case (state_q)
      IDLE: if (cmd_valid) begin
        if (cmd == 3'd1) begin
          init_done_d = 1'b0;
          op_d        = OP_INIT;
          step_d      = '0;
          cnt_d       = '0;
          state_d     = PWRUP;
        end else if (!init_done_q) begin
          err_d = 1'b1;
        end else begin
          case (cmd)
            3'd2: begin
              op_d = OP_WRITE; launch = 1'b1; l_byte = cmd_data; l_rs = 1'b1;
            end
            3'd3: begin
              if (32'(cmd_row) >= 32'(ROWS) || 32'(cmd_col) >= 32'(COLS)) begin
                err_d = 1'b1;
              end else begin
                row_d = cmd_row; col_d = cmd_col; op_d = OP_ADDR;
                launch = 1'b1; l_byte = ddram_cmd(cmd_row, cmd_col);
              end
            end
            3'd4: begin
              op_d = OP_CLEAR; launch = 1'b1; l_byte = 8'h01; l_wlen = 32'(T_LONG);
            end
            3'd5: begin
              // Backlight byte bypasses the EN strobe and the settle wait
              bl_d        = cmd_data[0];
              op_d        = OP_BL;
              single_d    = 1'b1;
              nowait_d    = 1'b1;
              out_data_d  = {4'h0, cmd_data[0], 3'b000};
              out_valid_d = 1'b1;
              state_d     = NIB_E0;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      PWRUP: begin
        if (cnt_q >= 32'(T_PWRUP) - 32'd1) begin
          cnt_d = '0; state_d = NEXT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      NIB_E1: if (out_ready) begin
        out_data_d = out_data_q & 8'hFB;
        state_d    = NIB_E0;
      end
      NIB_E0: if (out_ready) begin
        if (!single_q) begin
          single_d    = 1'b1;
          out_data_d  = {byte_q[3:0], bl_q, 1'b1, 1'b0, rs_q};
          state_d     = NIB_E1;
        end else begin
          out_valid_d = 1'b0;
          out_data_d  = '0;
          cnt_d       = '0;
          state_d     = nowait_q ? NEXT : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q >= wlen_q - 32'd1) begin
          state_d = NEXT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      NEXT: begin
        state_d = IDLE;
        case (op_q)
          OP_INIT: begin
            if (step_q == 4'd8) begin
              init_done_d = 1'b1; row_d = '0; col_d = '0;
            end else begin
              launch = 1'b1; l_byte = ini_byte; l_single = ini_single; l_wlen = ini_wlen;
              step_d = step_q + 4'd1;
            end
          end
          OP_WRITE: begin
            if (32'(col_q) + 32'd1 >= 32'(COLS)) begin
              col_d = '0; row_d = nrow; op_d = OP_ADDR;
              launch = 1'b1; l_byte = ddram_cmd(nrow, 6'd0);
            end else begin
              col_d = col_q + 6'd1;
            end
          end
          OP_CLEAR: begin row_d = '0; col_d = '0; end
          default: ;
        endcase
      end
      default: state_d = IDLE;
    endcase

    // single_q doubles as "low nibble pending is done": a full byte starts with it
    // clear and sets it when switching to the low nibble.
    if (launch) begin
      byte_d      = l_byte;
      rs_d        = l_rs;
      single_d    = l_single;
      nowait_d    = 1'b0;
      wlen_d      = l_wlen;
      out_data_d  = {l_byte[7:4], bl_q, 1'b1, 1'b0, l_rs};
      out_valid_d = 1'b1;
      state_d     = NIB_E1;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= OP_INIT;
      step_q      <= '0;
      byte_q      <= '0;
      rs_q        <= 1'b0;
      single_q    <= 1'b0;
      nowait_q    <= 1'b0;
      wlen_q      <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      bl_q        <= BL_DEFAULT;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      step_q      <= step_d;
      byte_q      <= byte_d;
      rs_q        <= rs_d;
      single_q    <= single_d;
      nowait_q    <= nowait_d;
      wlen_q      <= wlen_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      bl_q        <= bl_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
      row_q       <= row_d;
      col_q       <= col_d;
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign init_done  = init_done_q;
  assign err        = err_q;
  assign cursor_row = row_q;
  assign cursor_col = col_q;

endmodule

// File: tb/tb_hd44780_ctrl.sv
// Self-checking bench for hd44780_ctrl: a command-level model predicts the
// expander byte stream, minimum spacing and final cursor/init state.
module tb_hd44780_ctrl;

  localparam int ROWS = 2;
  localparam int COLS = 16;
  localparam int TP   = 4;
  localparam int TI   = 6;
  localparam int TC   = 4;
  localparam int TL   = 9;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] cmd = '0;
  logic [7:0] cmd_data = '0;
  logic [1:0] cmd_row = '0;
  logic [5:0] cmd_col = '0;
  logic       cmd_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic       cmd_ready, out_valid, busy, init_done, err;
  logic [7:0] out_data;
  logic [1:0] cursor_row;
  logic [5:0] cursor_col;

  hd44780_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .T_PWRUP(TP), .T_INIT(TI), .T_CMD(TC), .T_LONG(TL),
    .BL_DEFAULT(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .cmd_data(cmd_data), .cmd_row(cmd_row),
    .cmd_col(cmd_col), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .init_done(init_done), .err(err),
    .cursor_row(cursor_row), .cursor_col(cursor_col)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nfail = 0;

  task automatic chk_eq(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {logic [7:0] d; int g;} exp_t;
  exp_t exp_q[$];
  int   pend = 1;
  bit   no_max = 1'b0;
  int   m_row = 0, m_col = 0;
  bit   m_bl = 1'b1, m_init = 1'b0;
  bit   cur_err = 1'b0;

  function automatic int ddram(input int r, input int c);
    return (r % 2) * 64 + (r / 2) * COLS + c;
  endfunction

  task automatic push_raw(input logic [7:0] d);
    exp_q.push_back('{d: d, g: pend});
    pend = 1;
  endtask

  task automatic push_nib(input logic [3:0] n, input bit rs);
    push_raw({n, m_bl, 1'b1, 1'b0, rs});
    push_raw({n, m_bl, 1'b0, 1'b0, rs});
  endtask

  task automatic push_ins(input logic [7:0] b, input bit rs, input int w);
    push_nib(b[7:4], rs);
    push_nib(b[3:0], rs);
    pend = w + 1;
  endtask

  task automatic push_init_nib(input logic [3:0] n, input int w);
    push_nib(n, 1'b0);
    pend = w + 1;
  endtask

  task automatic model_cmd(input int c, input int d, input int r, input int col, output bit e);
    logic [7:0] ab;
    e = 1'b0;
    pend = 1;
    if (c == 1) begin
      m_init = 1'b0;
      pend = TP + 1;
      push_init_nib(4'h3, TI);
      push_init_nib(4'h3, TC);
      push_init_nib(4'h3, TC);
      push_init_nib(4'h2, TC);
      push_ins((ROWS == 1) ? 8'h20 : 8'h28, 1'b0, TC);
      push_ins(8'h0C, 1'b0, TC);
      push_ins(8'h06, 1'b0, TC);
      push_ins(8'h01, 1'b0, TL);
      m_row = 0; m_col = 0; m_init = 1'b1;
    end else if (!m_init || c < 1 || c > 5) begin
      e = 1'b1;
    end else if (c == 2) begin
      push_ins(8'(d), 1'b1, TC);
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        m_row = (m_row + 1) % ROWS;
        ab = 8'(128 + ddram(m_row, m_col));
        push_ins(ab, 1'b0, TC);
      end
    end else if (c == 3) begin
      if (r >= ROWS || col >= COLS) e = 1'b1;
      else begin
        m_row = r; m_col = col;
        ab = 8'(128 + ddram(r, col));
        push_ins(ab, 1'b0, TC);
      end
    end else if (c == 4) begin
      push_ins(8'h01, 1'b0, TL);
      m_row = 0; m_col = 0;
    end else begin
      m_bl = d[0];
      push_raw({4'h0, m_bl, 3'b000});
    end
  endtask

  task automatic pin4(input string nm, input int b, input logic [7:0] a0,
                      input logic [7:0] a1, input logic [7:0] a2, input logic [7:0] a3);
    chk_eq({nm, "_0"}, int'(exp_q[b].d), int'(a0));
    chk_eq({nm, "_1"}, int'(exp_q[b+1].d), int'(a1));
    chk_eq({nm, "_2"}, int'(exp_q[b+2].d), int'(a2));
    chk_eq({nm, "_3"}, int'(exp_q[b+3].d), int'(a3));
  endtask

  // ---------------- compare process ----------------
  int         n = 0, last_evt = 0, err_cnt = 0, err_base = 0;
  bit         pv = 1'b0, pr = 1'b0;
  logic [7:0] pd = '0;
  exp_t       e_cur;

  always @(negedge clk) begin
    n++;
    if (rst) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        chk_eq("hold_valid", int'(out_valid), 1);
        chk_eq("hold_data", int'(out_data), int'(pd));
      end
      chk_eq("busy_vs_ready", int'(busy), int'(!cmd_ready));
      if (err) err_cnt++;
      if (cmd_valid && cmd_ready) last_evt = n;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          nchk++; nfail++;
          $display("FAIL extra_byte: got 0x%0h want none", out_data);
        end else begin
          e_cur = exp_q.pop_front();
          chk_eq("byte", int'(out_data), int'(e_cur.d));
          nchk++;
          if (n - last_evt < e_cur.g || (!no_max && n - last_evt > e_cur.g + 4)) begin
            nfail++;
            $display("FAIL byte_gap: got %0d want %0d..%0d", n - last_evt, e_cur.g, e_cur.g + 4);
          end
        end
        last_evt = n;
      end
      pv = out_valid; pr = out_ready; pd = out_data;
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input int c, input int d, input int r, input int col);
    int to = 0;
    while (!cmd_ready && to < 5000) begin @(posedge clk); #1; to++; end
    chk_eq("ready_before_cmd", int'(cmd_ready), 1);
    err_base = err_cnt;
    cmd = 3'(c); cmd_data = 8'(d); cmd_row = 2'(r); cmd_col = 6'(col);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk_eq("err_pulse", int'(err), int'(cur_err));
    if (!cur_err) chk_eq("busy_after_accept", int'(busy), 1);
    if (c == 1) chk_eq("init_done_drop", int'(init_done), 0);
  endtask

  task automatic finish_cmd();
    int to = 0;
    while (busy && to < 5000) begin @(posedge clk); #1; to++; end
    chk_eq("busy_done", int'(busy), 0);
    @(posedge clk); #1;
    chk_eq("cursor_row", int'(cursor_row), m_row);
    chk_eq("cursor_col", int'(cursor_col), m_col);
    chk_eq("init_done", int'(init_done), int'(m_init));
    chk_eq("pending_bytes", exp_q.size(), 0);
    chk_eq("err_count", err_cnt - err_base, int'(cur_err));
    no_max = 1'b0;
  endtask

  task automatic do_cmd(input int c, input int d, input int r, input int col, input int stall);
    model_cmd(c, d, r, col, cur_err);
    issue(c, d, r, col);
    if (stall > 0) begin
      repeat (stall) begin @(posedge clk); #1; end
      no_max = 1'b1;
      out_ready = 1'b0;
      repeat (20) begin
        @(posedge clk); #1;
        chk_eq("stall_busy", int'(busy), 1);
        chk_eq("stall_valid", int'(out_valid), 1);
      end
      out_ready = 1'b1;
    end
    finish_cmd();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int to;
    repeat (2) @(posedge clk);
    #1;
    chk_eq("rst_cmd_ready", int'(cmd_ready), 1);
    chk_eq("rst_out_valid", int'(out_valid), 0);
    chk_eq("rst_out_data", int'(out_data), 0);
    chk_eq("rst_busy", int'(busy), 0);
    chk_eq("rst_init_done", int'(init_done), 0);
    chk_eq("rst_err", int'(err), 0);
    chk_eq("rst_row", int'(cursor_row), 0);
    chk_eq("rst_col", int'(cursor_col), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // commands before INIT are rejected
    do_cmd(2, 'h41, 0, 0, 0);
    chk_eq("pre_init_write_err", int'(cur_err), 1);
    do_cmd(0, 0, 0, 0, 0);

    // INIT
    model_cmd(1, 0, 0, 0, cur_err);
    chk_eq("pin_init_first", int'(exp_q[0].d), 'h3C);
    chk_eq("pin_init_second", int'(exp_q[1].d), 'h38);
    chk_eq("pin_init_gap", exp_q[0].g, TP + 1);
    b = exp_q.size() - 4;
    pin4("pin_init_clear", b, 8'h0C, 8'h08, 8'h1C, 8'h18);
    issue(1, 0, 0, 0);
    finish_cmd();

    // WRITE 'A'
    b = exp_q.size();
    model_cmd(2, 'h41, 0, 0, cur_err);
    pin4("pin_write", b, 8'h4D, 8'h49, 8'h1D, 8'h19);
    issue(2, 'h41, 0, 0);
    finish_cmd();
    chk_eq("write_col", int'(cursor_col), 1);

    // GOTO legal and out of range, illegal codes
    b = exp_q.size();
    model_cmd(3, 0, 1, 3, cur_err);
    pin4("pin_goto", b, 8'hCC, 8'hC8, 8'h3C, 8'h38);
    issue(3, 0, 1, 3);
    finish_cmd();
    do_cmd(3, 0, 2, 0, 0);
    do_cmd(3, 0, 0, COLS, 0);
    do_cmd(0, 0, 0, 0, 0);
    do_cmd(6, 0, 0, 0, 0);
    do_cmd(7, 0, 0, 0, 0);

    // line wrap and panel wrap
    do_cmd(3, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      b = exp_q.size();
      model_cmd(2, 'h41 + (i % 26), 0, 0, cur_err);
      if (i == 15) pin4("pin_wrap_line", b + 4, 8'hCC, 8'hC8, 8'h0C, 8'h08);
      if (i == 31) pin4("pin_wrap_panel", b + 4, 8'h8C, 8'h88, 8'h0C, 8'h08);
      issue(2, 'h41 + (i % 26), 0, 0);
      finish_cmd();
      if (i == 15) begin
        chk_eq("wrap1_row", int'(cursor_row), 1);
        chk_eq("wrap1_col", int'(cursor_col), 0);
      end
    end
    chk_eq("wrap2_row", int'(cursor_row), 0);
    chk_eq("wrap2_col", int'(cursor_col), 0);

    // stall mid-WRITE
    do_cmd(2, 'h5A, 0, 0, 2);

    // CLEAR
    do_cmd(4, 0, 0, 0, 0);

    // BACKLIGHT off, write with backlight off, BACKLIGHT on
    b = exp_q.size();
    model_cmd(5, 0, 0, 0, cur_err);
    chk_eq("pin_bl_off", int'(exp_q[b].d), 'h00);
    issue(5, 0, 0, 0);
    finish_cmd();
    b = exp_q.size();
    model_cmd(2, 'h41, 0, 0, cur_err);
    pin4("pin_write_bl0", b, 8'h45, 8'h41, 8'h15, 8'h11);
    issue(2, 'h41, 0, 0);
    finish_cmd();
    b = exp_q.size();
    model_cmd(5, 1, 0, 0, cur_err);
    chk_eq("pin_bl_on", int'(exp_q[b].d), 'h08);
    issue(5, 1, 0, 0);
    finish_cmd();

    // re-INIT while initialised
    do_cmd(1, 0, 0, 0, 0);

    // reset in the middle of INIT
    model_cmd(1, 0, 0, 0, cur_err);
    issue(1, 0, 0, 0);
    to = 0;
    while (!out_valid && to < 100) begin @(posedge clk); #1; to++; end
    chk_eq("pre_rst_valid", int'(out_valid), 1);
    rst = 1'b1;
    #1;
    chk_eq("midrst_out_valid", int'(out_valid), 0);
    chk_eq("midrst_init_done", int'(init_done), 0);
    chk_eq("midrst_busy", int'(busy), 0);
    chk_eq("midrst_out_data", int'(out_data), 0);
    exp_q.delete();
    m_init = 1'b0; m_row = 0; m_col = 0; m_bl = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk_eq("post_rst_ready", int'(cmd_ready), 1);
    chk_eq("post_rst_busy", int'(busy), 0);
    chk_eq("post_rst_valid", int'(out_valid), 0);
    do_cmd(2, 'h41, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/hd44780_ctrl.md
Name: hd44780_ctrl

Overview:
- Parametrised HD44780 character-LCD controller for PCF8574-style I2C backpacks, driving the panel in 4-bit mode.
- Converts high-level commands (INIT, WRITE, GOTO, CLEAR, BACKLIGHT) into a stream of expander bytes on a valid/ready port.
- The stream feeds the existing I2C byte master, which is not contained in this block.
- Generalised over panel geometry (1/2/4 rows, up to 40 columns).
- Tracks the cursor, auto-wraps at end of line and end of panel, and enforces per-instruction settle delays.

Parameters:
- ROWS, 2, panel rows; legal values 1, 2, 4.
- COLS, 16, panel columns; legal range 8..40.
- T_PWRUP, 750000, clk cycles waited before the first init nibble.
- T_INIT, 250000, cycles waited after the first 0x3 nibble.
- T_CMD, 2500, cycles waited after every normal instruction or data byte.
- T_LONG, 100000, cycles waited after clear (0x01).
- BL_DEFAULT, 1, backlight bit value after reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- cmd  in  3  command code: 1=INIT, 2=WRITE, 3=GOTO, 4=CLEAR, 5=BACKLIGHT; 0, 6 and 7 are illegal.
- cmd_data  in  8  character for WRITE; bit0 carries the backlight value for BACKLIGHT.
- cmd_row  in  2  target row for GOTO.
- cmd_col  in  6  target column for GOTO.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- out_data  out  8  expander byte: [7:4]=D7..D4, [3]=BL, [2]=EN, [1]=RW (always 0), [0]=RS.
- out_valid  out  1  expander byte present.
- out_ready  in  1  I2C master accepts the byte when out_valid && out_ready.
- busy  out  1  high whenever the FSM is not in IDLE.
- init_done  out  1  init sequence has completed.
- err  out  1  one-cycle pulse when a command is rejected.
- cursor_row  out  2  current cursor row.
- cursor_col  out  6  current cursor column.

Behaviour:
- Reset values: cmd_ready=1, out_valid=0, out_data=0, busy=0, init_done=0, err=0, cursor=0/0, bl=BL_DEFAULT.
- Reset is asynchronous and may assert mid-sequence: all outputs return to reset values immediately, no partial byte is completed, and the delay counter clears.
- FSM states: IDLE, PWRUP, NIB_E1, NIB_E0, WAIT, NEXT.
- cmd_ready=1 only in IDLE. A command is accepted on the cycle cmd_valid && cmd_ready; busy rises the next cycle.
- Nibble emission takes two bytes:
  - first byte: {nib, bl, 1, 0, rs};
  - second byte: {nib, bl, 0, 0, rs}.
- A full LCD byte is the high nibble then the low nibble, i.e. 4 expander bytes.
- out_data and out_valid hold stable until accepted. The next byte is presented on the cycle after acceptance at the earliest.
- The WAIT delay counter starts on the cycle the last byte of an instruction is accepted and runs for exactly the parameter's cycle count.
- INIT sequence:
  - PWRUP for T_PWRUP cycles;
  - nibble 3, wait T_INIT;
  - nibble 3, wait T_CMD;
  - nibble 3, wait T_CMD;
  - nibble 2, wait T_CMD;
  - bytes 0x28 (0x20 if ROWS=1), 0x0C, 0x06 (T_CMD after each);
  - 0x01, then wait T_LONG.
  - At the end: init_done=1, cursor=0/0, return to IDLE.
- INIT while init_done=1 re-runs the full sequence; init_done drops to 0 on acceptance.
- Any non-INIT command while init_done=0 is consumed, err pulses, and no bytes are emitted.
- WRITE: emit cmd_data with RS=1, wait T_CMD, then col+1.
  - If col reaches COLS: col=0 and row=(row+1) mod ROWS.
  - After a wrap the FSM also emits set-DDRAM for the new position (RS=0) plus T_CMD before returning to IDLE.
- DDRAM address = ((row & 1) ? 0x40 : 0x00) + ((row >> 1) * COLS) + col. The set-DDRAM instruction is 0x80 | addr.
- GOTO: if cmd_row >= ROWS or cmd_col >= COLS, err pulses, the cursor is unchanged and nothing is emitted. Otherwise the cursor updates and set-DDRAM is emitted with T_CMD.
- CLEAR: emit 0x01, wait T_LONG, cursor=0/0.
- BACKLIGHT: bl <= cmd_data[0], then emit one byte {0000, bl, 0, 0, 0} with no EN and no wait.
- Illegal cmd codes: err pulses; nothing else changes.
- err is asserted only in the cycle after the rejecting handshake.
- Stalls: out_ready may stay low indefinitely. The FSM holds, and the delay counter does not start until the byte is accepted.

Test Plan:
- Set T_* = 4, ROWS=2, COLS=16, out_ready=1, then INIT. Required:
  - first bytes 0x3C, 0x38 appear only after 4 idle cycles;
  - the full stream ends with 0x0C, 0x08, 0x1C, 0x18 (clear);
  - then init_done=1 and busy=0.
- After init, WRITE 0x41. Required: bytes 0x4D, 0x49, 0x1D, 0x19, then cursor_col=1.
- GOTO row=1 col=3. Required: bytes 0xCC, 0xC8, 0x3C, 0x38 and cursor=1/3. GOTO row=2 col=0 → err pulse, no bytes.
- WRITE 16 characters from 0/0. Required: after the 16th character the bytes 0xCC, 0xC8, 0x0C, 0x08 (DDRAM 0x40) follow and cursor=1/0. Writing 16 more wraps the cursor to 0/0 with bytes 0x8C, 0x88, 0x0C, 0x08.
- Hold out_ready=0 for 20 cycles mid-WRITE. Required: out_data stays constant, busy=1, and no byte is lost or duplicated.
- Remaining cases:
  - WRITE before INIT → err pulse, no output.
  - BACKLIGHT 0 → single byte 0x00.
  - rst asserted mid-INIT → out_valid=0 and init_done=0 at once, and the FSM is in IDLE after release.
